// File: rtl/mem_wb_stage_if.sv
// EXE -> MEM/WB handoff bundle: valid/ready handshake plus the retired op fields.
// master = upstream EXE stage, slave = mem_wb_stage.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              exe_valid;
  logic              exe_ready;
  logic              exe_wb_en;
  logic              exe_mem_r;
  logic              exe_mem_w;
  logic [3:0]        exe_dest;
  logic [DATA_W-1:0] exe_alu_res;
  logic [DATA_W-1:0] exe_st_val;

  modport master (
    output exe_valid, exe_wb_en, exe_mem_r, exe_mem_w, exe_dest, exe_alu_res, exe_st_val,
    input  exe_ready
  );

  modport slave (
    input  exe_valid, exe_wb_en, exe_mem_r, exe_mem_w, exe_dest, exe_alu_res, exe_st_val,
    output exe_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access + write-back stage in front of the register file write port.
// ALU ops write back one edge after acceptance; 32-bit loads/stores run on a
// 16-bit SRAM as a low and a high half-word phase of WAIT_STATES+1 cycles each,
// followed by one DONE cycle. Upstream is frozen whenever the stage is not IDLE.
// Optional feature: define MEM_WB_FWD_EN to drive the fwd_* forwarding outputs;
// otherwise they are tied to zero.
module mem_wb_stage #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = DATA_W / 2,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_wb_stage_if.slave      exe,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_we_n,
  output logic               write_back_en,
  output logic [3:0]         dest_wb,
  output logic [DATA_W-1:0]  result_wb,
  output logic               fwd_valid,
  output logic [3:0]         fwd_dest,
  output logic [DATA_W-1:0]  fwd_data
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t            state;
  logic [2:0]        cnt;      // cycle index inside the current SRAM phase
  logic              op_load;  // latched op is a load (mem_r wins over mem_w)
  logic              op_wb;
  logic [3:0]        op_dest;
  logic [DATA_W-1:0] op_st;
  logic [DATA_W-1:0] rd_buf;   // assembled load data, low half first

  // Ready only in IDLE; freeze is its complement for the hazard unit.
  assign exe.exe_ready = (state == IDLE);
  assign freeze        = (state != IDLE);

  // Single FSM with registered SRAM and register-file outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      write_back_en <= 1'b0;
      dest_wb       <= '0;
      result_wb     <= '0;
      sram_addr     <= '0;
      sram_dq_o     <= '0;
      sram_dq_oe    <= 1'b0;
      sram_we_n     <= 1'b1;
      op_load       <= 1'b0;
      op_wb         <= 1'b0;
      op_dest       <= '0;
      op_st         <= '0;
      rd_buf        <= '0;
    end else begin
      // Write-back is a single-cycle pulse, never held.
      write_back_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exe.exe_valid) begin
            if (exe.exe_mem_r || exe.exe_mem_w) begin
              state      <= LO;
              cnt        <= '0;
              op_load    <= exe.exe_mem_r;
              op_wb      <= exe.exe_wb_en;
              op_dest    <= exe.exe_dest;
              op_st      <= exe.exe_st_val;
              sram_addr  <= {exe.exe_alu_res[SRAM_AW:2], 1'b0};
              sram_dq_o  <= exe.exe_st_val[SRAM_DW-1:0];
              sram_dq_oe <= !exe.exe_mem_r;
              // With no wait states the single LO cycle is also its last, so the
              // strobe must stay high to keep the address change glitch-free.
              sram_we_n  <= exe.exe_mem_r || (WS == 3'd0);
            end else begin
              write_back_en <= exe.exe_wb_en;
              dest_wb       <= exe.exe_dest;
              result_wb     <= exe.exe_alu_res;
            end
          end
        end
        LO: begin
          if (cnt == WS) begin
            rd_buf[SRAM_DW-1:0] <= sram_dq_i;
            state               <= HI;
            cnt                 <= '0;
            sram_addr[0]        <= 1'b1;
            sram_dq_o           <= op_st[DATA_W-1:SRAM_DW];
            sram_we_n           <= op_load;
          end else begin
            cnt <= cnt + 3'd1;
            // Release the strobe for the last LO cycle before the address moves.
            if (cnt + 3'd1 == WS) sram_we_n <= 1'b1;
          end
        end
        HI: begin
          if (cnt == WS) begin
            rd_buf[DATA_W-1:SRAM_DW] <= sram_dq_i;
            state                    <= DONE;
            cnt                      <= '0;
            sram_we_n                <= 1'b1;
            sram_dq_oe               <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (op_load) begin
            write_back_en <= op_wb;
            dest_wb       <= op_dest;
            result_wb     <= rd_buf;
          end
        end
      endcase
    end
  end

`ifdef MEM_WB_FWD_EN
  // Expose the write being issued now, or the load result about to be issued.
  always_comb begin
    fwd_valid = write_back_en || (state == DONE && op_load && op_wb);
    fwd_dest  = write_back_en ? dest_wb   : op_dest;
    fwd_data  = write_back_en ? result_wb : rd_buf;
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage with a behavioural SRAM and a
// word-level reference memory. Honours MEM_WB_FWD_EN for the forwarding checks.
module tb_mem_wb_stage;
  localparam int WS = 1;
  localparam int F  = 2 * (WS + 1) + 1;   // busy cycles of a memory op

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_we_n;
  logic        write_back_en;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage_if #(.DATA_W(32)) exe_if ();

  mem_wb_stage #(.DATA_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .exe(exe_if), .freeze(freeze),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n),
    .write_back_en(write_back_en), .dest_wb(dest_wb), .result_wb(result_wb),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Power-up SRAM contents; two locations are pinned for the directed load.
  function automatic logic [15:0] init_hw(input int a);
    if (a == 'h204) return 16'hBEEF;
    if (a == 'h205) return 16'hDEAD;
    return 16'((a * 40503) ^ (a >> 3) ^ 16'h5A5A);
  endfunction

  // Asynchronous SRAM device: combinational read, write on clock while we_n low.
  bit [15:0] sram_mem [0:(1<<18)-1];
  bit        sram_wr  [0:(1<<18)-1];
  always_comb sram_dq_i = sram_wr[sram_addr] ? sram_mem[sram_addr] : init_hw(int'(sram_addr));
  always @(posedge clk) begin
    if (!sram_we_n) begin
      sram_mem[sram_addr] <= sram_dq_o;
      sram_wr[sram_addr]  <= 1'b1;
    end
  end

  // Reference: 32-bit words keyed by word index.
  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_read(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {init_hw(2 * w + 1), init_hw(2 * w)};
  endfunction

  task automatic check_fwd(input string tag, input bit exp_v, input logic [3:0] d, input logic [31:0] v);
`ifdef MEM_WB_FWD_EN
    check_eq({tag, "_fwd_valid"}, 32'(fwd_valid), 32'(exp_v));
    if (exp_v) begin
      check_eq({tag, "_fwd_dest"}, 32'(fwd_dest), 32'(d));
      check_eq({tag, "_fwd_data"}, fwd_data, v);
    end
`else
    check_eq({tag, "_fwd_valid"}, 32'(fwd_valid), 32'(0));
    check_eq({tag, "_fwd_data"}, fwd_data, 32'(0));
`endif
  endtask

  task automatic drive(input bit v, input bit r, input bit w, input bit wb,
                       input logic [3:0] d, input logic [31:0] alu, input logic [31:0] st);
    exe_if.exe_valid   = v;
    exe_if.exe_mem_r   = r;
    exe_if.exe_mem_w   = w;
    exe_if.exe_wb_en   = wb;
    exe_if.exe_dest    = d;
    exe_if.exe_alu_res = alu;
    exe_if.exe_st_val  = st;
  endtask

  // One op issued from IDLE, checked cycle by cycle until it has written back.
  task automatic run_op(input bit r, input bit w, input bit wb, input logic [3:0] d,
                        input logic [31:0] alu, input logic [31:0] st);
    bit          is_mem  = r || w;
    bit          is_load = r;
    int          word    = int'(alu[18:2]);
    logic [31:0] exp_ld;
    bit          half;
    @(negedge clk);
    check_eq("ready_idle", 32'(exe_if.exe_ready), 32'(1));
    drive(1'b1, r, w, wb, d, alu, st);
    if (!is_mem) begin
      @(negedge clk);
      drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 4'($urandom), $urandom, $urandom);
      check_eq("alu_wb_en", 32'(write_back_en), 32'(wb));
      if (wb) begin
        check_eq("alu_dest", 32'(dest_wb), 32'(d));
        check_eq("alu_result", result_wb, alu);
      end
      check_fwd("alu", wb, d, alu);
      @(negedge clk);
      check_eq("alu_wb_drop", 32'(write_back_en), 32'(0));
      $display("op alu  dest=%0d res=%08h wb=%0b", d, alu, wb);
    end else begin
      exp_ld = ref_read(word);
      if (!is_load) ref_mem[word] = st;
      for (int i = 0; i < F; i++) begin
        @(negedge clk);
        drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 4'($urandom), $urandom, $urandom);
        check_eq("busy_freeze", 32'(freeze), 32'(1));
        check_eq("busy_ready", 32'(exe_if.exe_ready), 32'(0));
        check_eq("busy_wb", 32'(write_back_en), 32'(0));
        if (i < 2 * (WS + 1)) begin
          half = (i >= WS + 1);
          check_eq("sram_addr", 32'(sram_addr), 32'({alu[18:2], half}));
          check_eq("sram_oe", 32'(sram_dq_oe), 32'(!is_load));
          check_eq("sram_we_n", 32'(sram_we_n), 32'(is_load || (!half && i == WS)));
          if (!is_load) check_eq("sram_dq_o", 32'(sram_dq_o), half ? 32'(st[31:16]) : 32'(st[15:0]));
        end else begin
          check_eq("done_we_n", 32'(sram_we_n), 32'(1));
          check_eq("done_oe", 32'(sram_dq_oe), 32'(0));
          check_fwd("done", is_load && wb, d, exp_ld);
        end
      end
      @(negedge clk);
      check_eq("mem_ready", 32'(exe_if.exe_ready), 32'(1));
      check_eq("mem_wb_en", 32'(write_back_en), 32'(is_load && wb));
      if (is_load && wb) begin
        check_eq("load_dest", 32'(dest_wb), 32'(d));
        check_eq("load_result", result_wb, exp_ld);
      end
      check_fwd("mem", is_load && wb, d, exp_ld);
      $display("op %s addr=%08h dest=%0d st=%08h exp=%08h wb=%0b",
               is_load ? "load " : "store", alu, d, st, exp_ld, wb);
    end
  endtask

  int          pool [8];
  logic [3:0]  bb_dest [3];
  logic [31:0] bb_res [3];

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    // Reset values while rst is held low.
    check_eq("rst_ready", 32'(exe_if.exe_ready), 32'(1));
    check_eq("rst_freeze", 32'(freeze), 32'(0));
    check_eq("rst_we_n", 32'(sram_we_n), 32'(1));
    check_eq("rst_oe", 32'(sram_dq_oe), 32'(0));
    check_eq("rst_addr", 32'(sram_addr), 32'(0));
    check_eq("rst_wb", 32'(write_back_en), 32'(0));
    check_eq("rst_result", result_wb, 32'(0));
    check_eq("rst_fwd", 32'(fwd_valid), 32'(0));
    $display("reset checked");
    rst = 1'b1;

    // Directed: ALU op, load 0x408, store then reload 0x10.
    run_op(1'b0, 1'b0, 1'b1, 4'd5, 32'h0000_1234, 32'h0);
    run_op(1'b1, 1'b0, 1'b1, 4'd3, 32'h0000_0408, 32'h0);
    check_eq("load_0x408", result_wb, 32'hDEADBEEF);
    run_op(1'b0, 1'b1, 1'b1, 4'd7, 32'h0000_0010, 32'hCAFEF00D);
    run_op(1'b1, 1'b0, 1'b1, 4'd9, 32'h0000_0010, 32'h0);
    check_eq("reload_0x10", result_wb, 32'hCAFEF00D);

    // Three back-to-back ALU ops: one pulse per cycle, never stalled.
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        check_eq("b2b_wb", 32'(write_back_en), 32'(1));
        check_eq("b2b_dest", 32'(dest_wb), 32'(bb_dest[j-1]));
        check_eq("b2b_result", result_wb, bb_res[j-1]);
      end
      if (j < 3) begin
        bb_dest[j] = 4'($urandom);
        bb_res[j]  = $urandom;
        check_eq("b2b_ready", 32'(exe_if.exe_ready), 32'(1));
        drive(1'b1, 1'b0, 1'b0, 1'b1, bb_dest[j], bb_res[j], 32'h0);
        @(negedge clk);
        $display("op b2b  dest=%0d res=%08h", bb_dest[j], bb_res[j]);
      end else begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      end
    end
    @(negedge clk);
    check_eq("b2b_drop", 32'(write_back_en), 32'(0));

    // Randomized mix over a small address pool so loads hit earlier stores.
    foreach (pool[k]) pool[k] = $urandom_range(0, (1 << 17) - 2);
    for (int n = 0; n < 60; n++) begin
      int          kind = $urandom_range(0, 3);
      logic [31:0] alu  = {13'($urandom), 17'(pool[$urandom_range(0, 7)]), 2'($urandom)};
      case (kind)
        0: run_op(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
        1: run_op(1'b1, 1'b0, 1'($urandom), 4'($urandom), alu, $urandom);
        2: run_op(1'b0, 1'b1, 1'($urandom), 4'($urandom), alu, $urandom);
        default: run_op(1'b1, 1'b1, 1'($urandom), 4'($urandom), alu, $urandom);
      endcase
    end

    // Reset during the HI phase of a store to a word outside the pool.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h0007_FFFC, 32'h1111_2222);
    repeat (WS + 2) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    check_eq("pre_rst_half", 32'(sram_addr[0]), 32'(1));
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_we_n", 32'(sram_we_n), 32'(1));
    check_eq("midrst_oe", 32'(sram_dq_oe), 32'(0));
    check_eq("midrst_ready", 32'(exe_if.exe_ready), 32'(1));
    check_eq("midrst_wb", 32'(write_back_en), 32'(0));
    rst = 1'b1;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      check_eq("postrst_wb", 32'(write_back_en), 32'(0));
      check_eq("postrst_ready", 32'(exe_if.exe_ready), 32'(1));
    end
    $display("reset during store checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
